// File: rtl/stop_watch_param.sv
// Parameterised BCD stopwatch: prescaled up/down digit chain with sticky wrap
// flag and a frozen "lap" display view.
module stop_watch_param #(
  parameter int CLK_DIV = 5000000,
  parameter int N_DIG   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic               clr,
  input  logic               up,
  input  logic               lap,
  output logic [4*N_DIG-1:0] bcd,
  output logic               ovf,
  output logic               tick,
  output logic               lap_active
);

  localparam int W  = 4 * N_DIG;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic {LIVE = 1'b0, LAP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    lap_q, lap_d;
  logic            ovf_q, ovf_d;
  logic            tick_q, tick_d;
  logic [W:0]      step_res_s;

  // Returns {wrap, next value}; wrap is the carry/borrow out of the top digit.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic dir_up);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < N_DIG; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (dir_up) begin
          if (d >= 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return {c, r};
  endfunction

  // State registers; tick is registered so it is high while the new count is shown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LIVE;
      presc_q <= {PW{1'b0}};
      cnt_q   <= {W{1'b0}};
      lap_q   <= {W{1'b0}};
      ovf_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    lap_d      = lap_q;
    ovf_d      = ovf_q;
    tick_d     = 1'b0;
    step_res_s = bcd_step(cnt_q, up);
    if (clr) begin
      state_d = LIVE;
      presc_d = {PW{1'b0}};
      cnt_d   = {W{1'b0}};
      lap_d   = {W{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      if (go) begin
        if (presc_q == PMAX) begin
          presc_d = {PW{1'b0}};
          cnt_d   = step_res_s[W-1:0];
          tick_d  = 1'b1;
          if (step_res_s[W]) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end else begin
        presc_d = presc_q;
      end
      // Lap capture uses the pre-tick count, even on a tick edge.
      case (state_q)
        LIVE: begin
          if (lap) begin
            lap_d   = cnt_q;
            state_d = LAP;
          end else begin
            state_d = LIVE;
          end
        end
        LAP: begin
          if (lap) begin
            state_d = LIVE;
          end else begin
            state_d = LAP;
          end
        end
        default: state_d = LIVE;
      endcase
    end
  end

  assign bcd        = (state_q == LAP) ? lap_q : cnt_q;
  assign lap_active = (state_q == LAP);
  assign ovf        = ovf_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_stop_watch_param.sv
// Randomised and directed bench for stop_watch_param (CLK_DIV=4, N_DIG=2)
// against an integer-arithmetic reference model.
module tb_stop_watch_param;

  localparam int CLK_DIV = 4;
  localparam int N_DIG   = 2;
  localparam int MODV    = 100;

  logic       clk = 1'b0;
  logic       reset_n, go, clr, up, lap;
  logic [7:0] bcd;
  logic       ovf, tick, lap_active;

  int n_cmp = 0;
  int n_err = 0;
  int n_ticks = 0;

  // reference model state (plain integers)
  int m_cnt, m_pre, m_lap, m_mode, m_ovf, m_tick;

  stop_watch_param #(.CLK_DIV(CLK_DIV), .N_DIG(N_DIG)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .clr(clr), .up(up), .lap(lap),
    .bcd(bcd), .ovf(ovf), .tick(tick), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_lap = 0; m_mode = 0; m_ovf = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic g, input logic c, input logic u, input logic l);
    int old;
    old = m_cnt;
    m_tick = 0;
    if (c) begin
      model_reset();
    end else begin
      if (g) begin
        if (m_pre == CLK_DIV - 1) begin
          m_pre = 0;
          m_tick = 1;
          if (u) begin
            if (m_cnt == MODV - 1) m_ovf = 1;
            m_cnt = (m_cnt + 1) % MODV;
          end else begin
            if (m_cnt == 0) m_ovf = 1;
            m_cnt = (m_cnt + MODV - 1) % MODV;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (l) begin
        if (m_mode == 0) begin
          m_lap = old;
          m_mode = 1;
        end else begin
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic g, input logic c, input logic u, input logic l);
    go = g; clr = c; up = u; lap = l;
    @(posedge clk);
    model_step(g, c, u, l);
    #1;
    check_eq("bcd", 32'(bcd), 32'(to_bcd(m_mode != 0 ? m_lap : m_cnt)));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("lap_active", 32'(lap_active), 32'(m_mode));
    if (tick) n_ticks++;
  endtask

  // Called 1 time unit after a rising edge; asserts and releases reset between edges.
  task automatic async_reset();
    go = 1'b0; clr = 1'b0; up = 1'b0; lap = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_bcd", 32'(bcd), 32'd0);
    check_eq("arst_ovf", 32'(ovf), 32'd0);
    check_eq("arst_tick", 32'(tick), 32'd0);
    check_eq("arst_lap_active", 32'(lap_active), 32'd0);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic g, c, u, l;
    reset_n = 1'b0; go = 1'b0; clr = 1'b0; up = 1'b0; lap = 1'b0;
    model_reset();
    #12;
    check_eq("reset_bcd", 32'(bcd), 32'd0);
    check_eq("reset_ovf", 32'(ovf), 32'd0);
    check_eq("reset_tick", 32'(tick), 32'd0);
    check_eq("reset_lap_active", 32'(lap_active), 32'd0);
    reset_n = 1'b1;

    // count up from reset through a full wrap
    n_ticks = 0;
    repeat (36) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("up_09", 32'(bcd), 32'h09);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("up_10", 32'(bcd), 32'h10);
    repeat (360) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("up_wrap_bcd", 32'(bcd), 32'h00);
    check_eq("up_wrap_ovf", 32'(ovf), 32'd1);
    check_eq("up_tick_count", 32'(n_ticks), 32'd100);

    // count down from 00
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("dn_99", 32'(bcd), 32'h99);
    check_eq("dn_ovf", 32'(ovf), 32'd1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("dn_98", 32'(bcd), 32'h98);

    // lap on the tick edge at 23
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (95) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("lap_pre23", 32'(bcd), 32'h23);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("lap_tick_edge_tick", 32'(tick), 32'd1);
    check_eq("lap_hold23", 32'(bcd), 32'h23);
    check_eq("lap_active_on", 32'(lap_active), 32'd1);
    repeat (12) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("lap_still23", 32'(bcd), 32'h23);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("lap_release27", 32'(bcd), 32'h27);
    check_eq("lap_active_off", 32'(lap_active), 32'd0);

    // pause mid-interval
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_ticks = 0;
    repeat (7) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("pause_no_tick", 32'(n_ticks), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pause_resume_wait", 32'(tick), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pause_resume_tick", 32'(tick), 32'd1);

    // clr against lap, tick and ovf on one edge
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("clr_bcd", 32'(bcd), 32'h00);
    check_eq("clr_ovf", 32'(ovf), 32'd0);
    check_eq("clr_lap_active", 32'(lap_active), 32'd0);
    check_eq("clr_tick", 32'(tick), 32'd0);
    n_ticks = 0;
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("clr_no_early_tick", 32'(n_ticks), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("clr_tick_after4", 32'(tick), 32'd1);

    // async reset while in LAP at 57
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (228) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("lap57_bcd", 32'(bcd), 32'h57);
    check_eq("lap57_active", 32'(lap_active), 32'd1);
    async_reset();
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("post_rst_first", 32'(bcd), 32'h01);

    // randomised run
    u = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      g = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) u = ~u;
      if ($urandom_range(0, 29) == 0) g = ~g;
      if ($urandom_range(0, 799) == 0) begin
        async_reset();
      end else begin
        cycle(g, c, u, l);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stop_watch_param.md
STOP_WATCH_PARAM -- requirements
Module: stop_watch_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5000000, clk cycles per count tick (0.1 s at 50 MHz); legal range 2 or more.
REQ-002 SHALL have parameter N_DIG, default 3, number of BCD digits; legal range 1..8.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port go, input, 1, level; 1 = run, 0 = pause (prescaler and digits hold).
REQ-006 SHALL have port clr, input, 1, synchronous clear of count, prescaler, ovf and lap view.
REQ-007 SHALL have port up, input, 1, direction; 1 = count up, 0 = count down.
REQ-008 SHALL have port lap, input, 1, single-cycle pulse toggling the lap (frozen display) view.
REQ-009 SHALL have port bcd, output, 4*N_DIG, displayed value; digit 0 (least significant) in bits [3:0].
REQ-010 SHALL have port ovf, output, 1, sticky flag for wrap in either direction.
REQ-011 SHALL have port tick, output, 1, one-cycle strobe on each count step.
REQ-012 SHALL have port lap_active, output, 1, 1 while the display is frozen.

Function
REQ-013 Prescaler SHALL be $clog2(CLK_DIV) bits wide, count 0..CLK_DIV-1 while go=1, and hold while go=0.
REQ-014 tick SHALL be 1 exactly when go=1 and prescaler=CLK_DIV-1; prescaler then returns to 0 next cycle.
REQ-015 On tick with up=1, digit chain SHALL increment as BCD; digit k carries when it and all lower digits are 9.
REQ-016 On tick with up=0, digit chain SHALL decrement as BCD; a digit at 0 borrows to 9.
REQ-017 Up wrap from all-9 SHALL give all-0 and set ovf; down wrap from all-0 SHALL give all-9 and set ovf.
REQ-018 ovf SHALL stay 1 until clr or reset.
REQ-019 No digit SHALL ever hold a value above 9.
REQ-020 up SHALL be sampled only on the tick cycle; changing it mid-interval SHALL NOT reset the prescaler.
REQ-021 View FSM SHALL have two states, LIVE and LAP; reset and clr enter LIVE.
REQ-022 In LIVE, a lap pulse SHALL copy the live count register into the lap register and move to LAP.
REQ-023 In LAP, a lap pulse SHALL return to LIVE.
REQ-024 bcd SHALL show the live count in LIVE and the lap register in LAP; lap_active = (state==LAP).
REQ-025 Counting SHALL continue in LAP.
REQ-026 If lap and tick fall on the same edge, the lap register SHALL capture the pre-tick value.
REQ-027 clr SHALL have priority over tick and lap: digits, prescaler, ovf and lap register go to 0 and the state goes to LIVE, whatever the other inputs are.
REQ-028 lap SHALL be honoured whether go is 0 or 1.
REQ-029 Outputs SHALL be registered or decoded from registers only, with no combinational path from inputs.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: prescaler 0, all digits 0, lap register 0, state LIVE, bcd 0, ovf 0, tick 0, lap_active 0.
REQ-031 A reset_n assert mid-interval or mid-lap SHALL discard all state; counting resumes from 0 only after deassert with go=1.
REQ-032 Deassertion SHALL be treated as synchronous to clk.

Verification (CLK_DIV=4, N_DIG=2 unless stated)
REQ-033 go=1, up=1 from reset -> tick every 4th cycle; bcd=0x09 then 0x10 after 10 ticks; after 100 ticks bcd=0x00 and ovf=1.
REQ-034 up=0 from 00 -> first tick gives bcd=0x99 and ovf=1; next tick gives 0x98.
REQ-035 At bcd=0x23, lap pulse on the tick edge -> bcd holds 0x23 and lap_active=1 while live reaches 0x27; second lap pulse -> bcd=0x27.
REQ-036 go toggled low for 7 cycles mid-interval -> no tick and prescaler holds; the tick period resumes with the remaining count.
REQ-037 clr with lap, tick and ovf all active on one edge -> bcd=0x00, ovf=0, lap_active=0, and the next tick is 4 cycles later.
REQ-038 reset_n pulse while in LAP with a count of 0x57 (N_DIG=3: 0x057) -> all outputs 0 immediately, without waiting for a clk edge.
